// File: rtl/clk_div2_monitor_pkg.sv
// Shared types and default parameters for the divide-by-2 clock monitor.
// Holds the FSM state encoding and the parameter defaults used by the top.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } mon_state_t;

    localparam int LOCK_COUNT_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_div2_monitor_edge_detect.sv
// Samples the divided clock once per system clock and flags changes.
// toggle and rise compare the live input against the previous sample.
module edge_detect (
    input  logic clk,
    input  logic an_rst,
    input  logic sig,
    output logic toggle,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!an_rst) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign toggle = sig ^ prev;
    assign rise   = sig & ~prev;

endmodule

// File: rtl/clk_div2_monitor.sv
// Watches a divide-by-2 clock: declares lock after a run of toggles,
// latches a sticky fault on any missed toggle, and counts rising edges.
module clk_div2_monitor
    import clk_mon_pkg::*;
#(
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             an_rst,
    input  logic             clk_div2,
    input  logic             clear,
    output logic             rise_pulse,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] edge_count
);

    localparam int               RUN_W    = count_width(LOCK_COUNT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);

    mon_state_t       state;
    mon_state_t       next_state;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             toggle;
    logic             rise;
    logic             count_en;

    edge_detect u_edge_detect (
        .clk    (clk),
        .an_rst (an_rst),
        .sig    (clk_div2),
        .toggle (toggle),
        .rise   (rise)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        run_next   = run_cnt;
        unique case (state)
            IDLE: begin
                next_state = LOCKING;
                run_next   = '0;
            end
            LOCKING: begin
                if (toggle) begin
                    run_next = run_cnt + 1'b1;
                    if (run_cnt == RUN_LAST) begin
                        next_state = LOCKED;
                    end
                end else begin
                    run_next = '0;
                end
            end
            LOCKED: begin
                if (!toggle) begin
                    next_state = FAULT;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = IDLE;
                run_next   = '0;
            end
        endcase
        // Clear overrides whatever the divider did this cycle.
        if (clear) begin
            next_state = IDLE;
            run_next   = '0;
        end
    end

    assign count_en = rise && (state != IDLE) && !clear;

    // Status flags are decoded from next_state so they track state exactly.
    always_ff @(posedge clk) begin
        if (!an_rst) begin
            state      <= IDLE;
            run_cnt    <= '0;
            rise_pulse <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            edge_count <= '0;
        end else begin
            state      <= next_state;
            run_cnt    <= run_next;
            rise_pulse <= count_en;
            locked     <= (next_state == LOCKED);
            fault      <= (next_state == FAULT);
            if (clear) begin
                edge_count <= '0;
            end else if (count_en && (edge_count != {CNT_W{1'b1}})) begin
                edge_count <= edge_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/clk_div2_monitor.md
CLK_DIV2_MONITOR -- requirements
Module: clk_div2_monitor

Interface
REQ-001 Parameter LOCK_COUNT, default 4, number of consecutive toggles required to declare lock (range 1..15).
REQ-002 Parameter CNT_W, default 16, width of edge_count.
REQ-003 clk  input  1  system clock; drives every flop in the block.
REQ-004 an_rst  input  1  reset, synchronous, active-low.
REQ-005 clk_div2  input  1  divided clock from the divide-by-2 stage, generated synchronously from clk.
REQ-006 clear  input  1  synchronous clear of fault, lock and count; active-high.
REQ-007 rise_pulse  output  1  one-cycle pulse per detected rising edge of clk_div2.
REQ-008 locked  output  1  divider judged healthy.
REQ-009 fault  output  1  sticky missed-toggle error.
REQ-010 edge_count  output  CNT_W  saturating count of rising edges since reset or clear.

Function
REQ-011 Block SHALL sample clk_div2 on every posedge clk into prev; toggle = (clk_div2 != prev); rise = clk_div2 & ~prev.
REQ-012 FSM states SHALL be IDLE, LOCKING, LOCKED, FAULT.
REQ-013 IDLE SHALL last exactly one cycle: capture prev, clear run counter, go to LOCKING.
REQ-014 LOCKING: toggle SHALL increment run counter; non-toggle SHALL reset run counter to 0 and stay in LOCKING; LOCK_COUNT-th consecutive toggle SHALL go to LOCKED.
REQ-015 LOCKED: toggle SHALL stay in LOCKED; non-toggle SHALL go to FAULT.
REQ-016 FAULT SHALL hold regardless of clk_div2 until clear or reset.
REQ-017 locked SHALL be registered, high exactly while state == LOCKED; fault SHALL be high exactly while state == FAULT.
REQ-018 rise_pulse SHALL be registered: high for one cycle, the cycle after the sample where rise = 1, in every state except IDLE.
REQ-019 edge_count SHALL increment by 1 on each rise (all states except IDLE), saturating at 2^CNT_W-1, no wrap.
REQ-020 clear SHALL force state IDLE, edge_count 0, rise_pulse 0 next cycle; clear beats any simultaneous toggle, rise or fault event.
REQ-021 Latency with a healthy divider: locked rises LOCK_COUNT+2 cycles after first cycle with an_rst high (6 cycles at default).

Reset
REQ-022 While an_rst is low at a posedge clk: state IDLE, prev 0, run counter 0, rise_pulse 0, locked 0, fault 0, edge_count 0.
REQ-023 Reset SHALL dominate clear and all events, including mid-LOCKED or mid-FAULT.
REQ-024 No flop SHALL change asynchronously to clk.

Structure
REQ-025 Package clk_mon_pkg SHALL hold state enum typedef mon_state_t, LOCK_COUNT default constant, CNT_W default constant.
REQ-026 Sub-module edge_detect (prev flop, toggle and rise outputs, clk/an_rst) SHALL be instantiated once; FSM and counters stay in top.
REQ-027 No combinational path from any input to any output.

Verification (clk period 2 ns, divide_clk_by_2 instance as stimulus unless stated)
REQ-028 an_rst=0 for 4 cycles with clk_div2 toggling -> all outputs 0 throughout.
REQ-029 Release reset, healthy divider -> locked=1 on 6th cycle after release, fault=0; edge_count=10 after 20 further cycles.
REQ-030 In LOCKED force clk_div2 unchanged for one cycle -> next cycle fault=1, locked=0; fault stays 1 after 10 healthy cycles.
REQ-031 In LOCKING, hold clk_div2 after 2 toggles -> locked stays 0; lock only after 4 further consecutive toggles.
REQ-032 clear=1 for one cycle in FAULT -> fault=0, edge_count=0 next cycle; relock 6 cycles after clear drops; clear and fault event in same cycle -> IDLE, fault=0.
REQ-033 CNT_W=4, healthy divider for 40 cycles -> edge_count stops at 15; an_rst=0 mid-LOCKED -> all outputs 0 next cycle.
